// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute controller for ArithmeticLogicUnitSystem
// Two-byte fetch into IR, single-cycle execute micro-ops, retired-instruction counter.
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      IROut,
    input  logic [3:0]       ALUOutFlag,
    output logic [2:0]       RF_OutASel,
    output logic [2:0]       RF_OutBSel,
    output logic [2:0]       RF_FunSel,
    output logic [3:0]       RF_RegSel,
    output logic [3:0]       RF_ScrSel,
    output logic [2:0]       ARF_FunSel,
    output logic [2:0]       ARF_RegSel,
    output logic [1:0]       ARF_OutCSel,
    output logic [1:0]       ARF_OutDSel,
    output logic [4:0]       ALU_FunSel,
    output logic             ALU_WF,
    output logic             IR_LH,
    output logic             IR_Write,
    output logic             Mem_CS,
    output logic             Mem_WR,
    output logic [1:0]       MuxASel,
    output logic [1:0]       MuxBSel,
    output logic             MuxCSel,
    output logic [2:0]       SeqState,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_LDI = 6'h02;
    localparam logic [5:0] OP_INC = 6'h03;
    localparam logic [5:0] OP_DEC = 6'h04;
    localparam logic [5:0] OP_ADD = 6'h05;
    localparam logic [5:0] OP_LD  = 6'h06;
    localparam logic [5:0] OP_ST  = 6'h07;
    localparam logic [5:0] OP_HLT = 6'h3F;

    localparam logic [2:0] FUN_DEC   = 3'b000;
    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;

    state_t           r_state;
    logic [CNT_W-1:0] r_instr_count;

    logic [5:0] w_opcode;
    logic [1:0] w_rsel;
    logic [1:0] w_sreg;
    logic [3:0] w_rf_onehot;
    logic       w_zero;
    logic       w_unused;

    assign w_opcode    = IROut[15:10];
    assign w_rsel      = IROut[9:8];
    assign w_sreg      = IROut[1:0];
    assign w_rf_onehot = 4'b1000 >> w_rsel;
    assign w_zero      = ALUOutFlag[3];
    // Immediate/address byte reaches the datapath through the muxes, not through control.
    assign w_unused    = ^{IROut[7:2], ALUOutFlag[2:0]};

    assign SeqState   = r_state;
    assign InstrCount = r_instr_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= S_INIT;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                S_INIT:    r_state <= S_FETCH_L;
                S_FETCH_L: r_state <= S_FETCH_H;
                S_FETCH_H: r_state <= S_EXEC;
                S_EXEC: begin
                    r_instr_count <= r_instr_count + 1'b1;
                    r_state       <= (w_opcode == OP_HLT) ? S_HALT : S_FETCH_L;
                end
                S_HALT:    r_state <= S_HALT;
                default:   r_state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ARF_FunSel  = 3'b000;
        ARF_RegSel  = 3'b000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;

        if (!Reset) begin
            case (r_state)
                S_INIT: begin
                    ARF_FunSel = FUN_CLEAR;
                    ARF_RegSel = 3'b111;
                    RF_FunSel  = FUN_CLEAR;
                    RF_RegSel  = 4'b1111;
                end
                S_FETCH_L, S_FETCH_H: begin
                    ARF_OutDSel = 2'b00;
                    Mem_CS      = 1'b0;
                    Mem_WR      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (r_state == S_FETCH_H);
                    ARF_FunSel  = FUN_INC;
                    ARF_RegSel  = 3'b100;
                end
                S_EXEC: begin
                    case (w_opcode)
                        OP_BRA: begin
                            MuxBSel    = 2'b11;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = 3'b100;
                        end
                        OP_BNE: begin
                            if (!w_zero) begin
                                MuxBSel    = 2'b11;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = 3'b100;
                            end
                        end
                        OP_LDI: begin
                            MuxASel   = 2'b11;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = w_rf_onehot;
                        end
                        OP_INC: begin
                            RF_FunSel = FUN_INC;
                            RF_RegSel = w_rf_onehot;
                        end
                        OP_DEC: begin
                            RF_FunSel = FUN_DEC;
                            RF_RegSel = w_rf_onehot;
                        end
                        OP_ADD: begin
                            RF_OutASel = {1'b1, w_rsel};
                            RF_OutBSel = {1'b1, w_sreg};
                            ALU_FunSel = 5'b10100;
                            ALU_WF     = 1'b1;
                            MuxASel    = 2'b00;
                            RF_FunSel  = FUN_LOAD;
                            RF_RegSel  = w_rf_onehot;
                        end
                        OP_LD: begin
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b0;
                            MuxASel     = 2'b10;
                            RF_FunSel   = FUN_LOAD;
                            RF_RegSel   = w_rf_onehot;
                        end
                        OP_ST: begin
                            RF_OutASel  = {1'b1, w_rsel};
                            ALU_FunSel  = 5'b10000;
                            MuxCSel     = 1'b0;
                            ARF_OutDSel = 2'b10;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed bench for control_sequencer with a small IR/PC stand-in
module tb_control_sequencer;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, ARF_RegSel, SeqState;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF, IR_LH, IR_Write, Mem_CS, Mem_WR, MuxCSel;
    logic [15:0] InstrCount;

    int checks;
    int failures;

    logic [7:0]  mem [256];
    logic [15:0] pc;
    logic [15:0] ir;

    control_sequencer #(.CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF), .IR_LH(IR_LH), .IR_Write(IR_Write),
        .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .SeqState(SeqState), .InstrCount(InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign IROut = ir;

    // Stand-in for memory, IR and PC, driven only by the controller's outputs.
    always @(posedge Clock) begin
        if (!Reset) begin
            if (IR_Write && !Mem_CS) begin
                if (IR_LH) ir[15:8] <= mem[pc[7:0]];
                else       ir[7:0]  <= mem[pc[7:0]];
            end
            if (ARF_RegSel[2]) begin
                case (ARF_FunSel)
                    3'b000:  pc <= pc - 16'd1;
                    3'b001:  pc <= pc + 16'd1;
                    3'b010:  pc <= {8'h00, IROut[7:0]};
                    default: pc <= 16'h0000;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h5A; mem[1] = 8'h0A;   // LDI R3,#5A
        mem[2] = 8'h40; mem[3] = 8'h04;   // BNE 0x40
        mem[4] = 8'h01; mem[5] = 8'h16;   // ADD R3,R2
        mem[6] = 8'h00; mem[7] = 8'hFC;   // HLT
        pc = 16'h1234;
        ir = 16'h0000;
        Reset = 1'b1;
        ALUOutFlag = 4'b0000;

        step(); step();
        check("rst_state", SeqState, 0);
        check("rst_cs", Mem_CS, 1);
        check("rst_rfregsel", RF_RegSel, 0);
        check("rst_count", InstrCount, 0);

        Reset = 1'b0;
        #1;
        check("init_state", SeqState, 0);
        check("init_arf_regsel", ARF_RegSel, 3'b111);
        check("init_arf_funsel", ARF_FunSel, 3'b011);
        check("init_rf_regsel", RF_RegSel, 4'b1111);
        check("init_rf_funsel", RF_FunSel, 3'b011);

        step();
        check("fl_state", SeqState, 1);
        check("fl_cs", Mem_CS, 0);
        check("fl_outd", ARF_OutDSel, 2'b00);
        check("fl_irw", IR_Write, 1);
        check("fl_lh", IR_LH, 0);
        check("fl_pc_inc", {ARF_RegSel, ARF_FunSel}, {3'b100, 3'b001});
        step();
        check("fh_state", SeqState, 2);
        check("fh_lh", IR_LH, 1);
        step();
        check("ldi_state", SeqState, 3);
        check("ldi_ir", ir, 16'h0A5A);
        check("ldi_muxa", MuxASel, 2'b11);
        check("ldi_funsel", RF_FunSel, 3'b010);
        check("ldi_regsel", RF_RegSel, 4'b0010);
        check("ldi_pc", pc, 16'h0002);
        check("ldi_count_pre", InstrCount, 0);

        step();
        check("ldi_count", InstrCount, 1);
        step(); step();
        ALUOutFlag = 4'b0000;
        #1;
        check("bne_z0_regsel", ARF_RegSel, 3'b100);
        check("bne_z0_funsel", ARF_FunSel, 3'b010);
        check("bne_z0_muxb", MuxBSel, 2'b11);
        ALUOutFlag = 4'b1000;
        #1;
        check("bne_z1_regsel", ARF_RegSel, 3'b000);

        step();
        check("bne_pc", pc, 16'h0004);
        check("bne_count", InstrCount, 2);
        step(); step();
        check("add_ir", ir, 16'h1601);
        check("add_outa", RF_OutASel, 3'b110);
        check("add_outb", RF_OutBSel, 3'b101);
        check("add_alu", ALU_FunSel, 5'b10100);
        check("add_wf", ALU_WF, 1);
        check("add_regsel", RF_RegSel, 4'b0010);
        check("add_muxa", MuxASel, 2'b00);

        step(); step(); step();
        check("hlt_exec_state", SeqState, 3);
        step();
        check("hlt_state", SeqState, 4);
        check("hlt_count", InstrCount, 4);
        repeat (5) step();
        check("hlt_state_hold", SeqState, 4);
        check("hlt_cs", Mem_CS, 1);
        check("hlt_count_hold", InstrCount, 4);

        Reset = 1'b1;
        step();
        check("hlt_rst_state", SeqState, 0);
        check("hlt_rst_count", InstrCount, 0);
        Reset = 1'b0;
        step(); step();
        check("abort_pre_state", SeqState, 2);
        Reset = 1'b1;
        step();
        check("abort_state", SeqState, 0);
        check("abort_irw", IR_Write, 0);
        check("abort_cs", Mem_CS, 1);
        check("abort_count", InstrCount, 0);
        check("abort_rfregsel", RF_RegSel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
